line_fill_queue: RTL and testbench
==================================

# line_fill_queue

Miss-fill request queue between the L1 instruction/data caches and the next-level cache. It accepts 26-bit line addresses (address bits [31:6]) from both L1 caches and merges duplicate requests to the same line. Requests are issued to the next level one at a time over a valid/ready handshake, and a per-requester fill-done pulse is returned when the line comes back. It also keeps issue and merge statistics for the statistics module.

## Interface
- `DEPTH`, 4: queue entries; legal range 2..16.
- `ADDR_W`, 26: line-address width (address bits [31:6]).
- `CNT_W`, 32: statistics counter width.

- `clk` in 1: the single clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ic_req_valid` in 1: instruction-cache line-fill request.
- `ic_req_addr` in ADDR_W: instruction-cache line address.
- `dc_req_valid` in 1: data-cache line-fill request.
- `dc_req_addr` in ADDR_W: data-cache line address.
- `req_ready` out 1: both request ports may present a request this cycle.
- `mem_req_valid` out 1: request to the next level.
- `mem_req_addr` out ADDR_W: line address of the head entry.
- `mem_req_ready` in 1: next level accepts the request.
- `mem_resp_valid` in 1: the line for the issued request has returned (single-cycle pulse).
- `ic_fill_done` out 1: one-cycle pulse; the instruction cache's line is available.
- `dc_fill_done` out 1: one-cycle pulse; the data cache's line is available.
- `issued_count` out CNT_W: number of next-level handshakes.
- `merged_count` out CNT_W: number of requests absorbed into an existing entry.
- `empty` out 1: queue holds no valid entry.

## Operation
- Each entry holds {valid, addr, src_mask[1:0]}. Bit 0 is IC and bit 1 is DC. The queue is circular, with head and tail pointers and a count.
- `req_ready = (count <= DEPTH-2)`. The value depends only on registered count, so there is no combinational path from the inputs.
- A request is accepted when valid && req_ready. A request presented while req_ready=0 is dropped; a requester must hold the request until it sees ready.
- Merge rule for an accepted request whose addr matches a valid entry:
  - The requester's bit is OR-ed into that entry's src_mask and merged_count increments by 1.
  - An entry being popped this cycle is excluded from the match, so the request allocates a new entry instead.
- An accepted request with no match allocates the entry at tail.
- IC and DC valid in the same cycle:
  - Same address, no match in the queue: one entry with mask 2'b11, merged_count +1.
  - Different addresses: DC is allocated first, then IC.
- FSM with states IDLE, REQ, WAIT.
  - IDLE: when count becomes nonzero, go to REQ on the next cycle.
  - REQ: mem_req_valid=1 and mem_req_addr=head addr. On mem_req_ready: issued_count +1, go to WAIT.
  - WAIT: on mem_resp_valid, pulse ic_fill_done and/or dc_fill_done per the head src_mask in that same cycle, and pop the head. The next state is REQ if a further entry exists (counting one enqueued this cycle), otherwise IDLE.
- mem_resp_valid in IDLE or REQ is ignored.
- Entries, including the head in WAIT, may be merged into at any time before they are popped. A merged bit is included in the fill-done pulse.
- Counters wrap modulo 2^CNT_W.
- Reset:
  - Clears every valid bit, the pointers, count, both counters and the FSM (to IDLE).
  - Output values in reset: req_ready=1, mem_req_valid=0, mem_req_addr=0, fill_done=0, empty=1.
  - Reset mid-transaction discards outstanding entries, and no fill_done is produced for them.
  - A response arriving after reset is ignored.

## Timing
- Accept at cycle t into an empty, IDLE queue: count=1 at t+1, FSM enters REQ at t+2, mem_req_valid=1 at t+2.
- mem_req_valid and mem_req_addr are stable until the handshake. mem_req_valid drops in the cycle after mem_req_ready.
- mem_resp_valid at cycle r gives fill_done at r (combinational from the head mask, registered inputs only). The entry is freed at r+1.
- Only one next-level request is outstanding at a time.

## Structure
- Package `line_fill_pkg` holds:
  - the FSM state enum (IDLE/REQ/WAIT);
  - the source index constants SRC_IC=0 and SRC_DC=1;
  - the default ADDR_W.
- Sub-module `lfq_match`: combinational parallel compare of one address against all entries, returning hit and a one-hot index, with an exclude-index input used for the popping head. It is instantiated twice, once for IC and once for DC.

## Test plan
- Single request:
  - Stimulus: IC addr 0x0000ABC at t; mem_req_ready=1 at t+2; mem_resp_valid at t+5.
  - Response: mem_req_valid at t+2 with addr 0x0000ABC; ic_fill_done at t+5; issued_count=1; empty at t+6.
- Same-cycle same address:
  - Stimulus: IC and DC both 0x1234567.
  - Response: one entry; on response both ic_fill_done and dc_fill_done pulse; merged_count=1; issued_count=1.
- Merge into an issued head:
  - Stimulus: DC 0x10 issued and in WAIT; IC 0x10 requested; then response.
  - Response: both pulses; merged_count=1; no second mem request.
- Fill and back-pressure (DEPTH=4):
  - Stimulus: hold mem_req_ready=0 and enqueue 3 distinct addresses.
  - Response: req_ready=0 with count=3; a 4th request is dropped. Issue order is DC before IC for same-cycle pairs, FIFO otherwise.
- Pop with re-request:
  - Stimulus: a new request for the head address arrives in the same cycle as its response.
  - Response: new entry allocated; a second mem request for the same address follows.
- Reset in WAIT with 2 entries:
  - Stimulus: reset, then a mem_resp_valid one cycle later.
  - Response: empty=1, no fill_done, counters 0, FSM IDLE.

Source files
------------

// File: rtl/line_fill_queue_pkg.sv
// Shared types and constants for the line-fill queue: FSM state, requester
// bit positions in the source mask, and the default line-address width.
package line_fill_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 26;

  localparam int unsigned SRC_IC = 0;
  localparam int unsigned SRC_DC = 1;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } lfq_state_e;

endpackage

// File: rtl/line_fill_queue_if.sv
// Request, next-level and statistics signals of the line-fill queue; the
// queue takes the slave side, the caches / next level drive the master side.
interface line_fill_queue_if #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned CNT_W  = 32
);
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              dc_req_valid;
  logic [ADDR_W-1:0] dc_req_addr;
  logic              req_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic              ic_fill_done;
  logic              dc_fill_done;
  logic [CNT_W-1:0]  issued_count;
  logic [CNT_W-1:0]  merged_count;
  logic              empty;

  modport slave (
    input  ic_req_valid, ic_req_addr, dc_req_valid, dc_req_addr,
    input  mem_req_ready, mem_resp_valid,
    output req_ready, mem_req_valid, mem_req_addr,
    output ic_fill_done, dc_fill_done, issued_count, merged_count, empty
  );

  modport master (
    output ic_req_valid, ic_req_addr, dc_req_valid, dc_req_addr,
    output mem_req_ready, mem_resp_valid,
    input  req_ready, mem_req_valid, mem_req_addr,
    input  ic_fill_done, dc_fill_done, issued_count, merged_count, empty
  );
endinterface

// File: rtl/line_fill_queue_match.sv
// Parallel compare of one line address against every queue entry; returns a
// one-hot hit vector, skipping entries flagged in i_exclude.
module lfq_match
  import line_fill_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DEPTH-1:0]  i_valid,
  input  logic [ADDR_W-1:0] i_entry_addr [DEPTH],
  input  logic [DEPTH-1:0]  i_exclude,
  output logic              o_hit,
  output logic [DEPTH-1:0]  o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_idx[i] = i_valid[i] && !i_exclude[i] && (i_entry_addr[i] == i_addr);
    end
  end

  assign o_hit = |o_idx;

endmodule

// File: rtl/line_fill_queue.sv
// Miss-fill queue: merges duplicate IC/DC line requests, issues them one at a
// time to the next level and returns per-requester fill-done pulses.
module line_fill_queue
  import line_fill_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned CNT_W  = 32
) (
  input logic           clk,
  input logic           reset,
  line_fill_queue_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NUM_W = $clog2(DEPTH + 1);
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [DEPTH-1:0]  r_valid, w_valid_d;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [ADDR_W-1:0] w_addr_d [DEPTH];
  logic [1:0]        r_mask [DEPTH];
  logic [1:0]        w_mask_d [DEPTH];
  ptr_t              r_head, r_tail, w_head_d, w_tail_d, w_dc_slot;
  logic [NUM_W-1:0]  r_count, w_count_d;
  lfq_state_e        r_state;
  logic [CNT_W-1:0]  r_issued, r_merged;

  logic             w_req_ready, w_ic_acc, w_dc_acc, w_same, w_pop;
  logic [DEPTH-1:0] w_excl, w_ic_idx, w_dc_idx;
  logic             w_ic_hit, w_dc_hit;
  logic [1:0]       w_allocs, w_merges;

  assign w_req_ready = (r_count <= NUM_W'(DEPTH - 2));
  assign w_ic_acc    = bus.ic_req_valid && w_req_ready;
  assign w_dc_acc    = bus.dc_req_valid && w_req_ready;
  assign w_same      = w_ic_acc && w_dc_acc && (bus.ic_req_addr == bus.dc_req_addr);
  assign w_pop       = (r_state == StWait) && bus.mem_resp_valid;

  // The head being popped cannot absorb a request; it would never be filled.
  always_comb begin
    w_excl = '0;
    if (w_pop) w_excl[r_head] = 1'b1;
  end

  lfq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match_ic (
    .i_addr       (bus.ic_req_addr),
    .i_valid      (r_valid),
    .i_entry_addr (r_addr),
    .i_exclude    (w_excl),
    .o_hit        (w_ic_hit),
    .o_idx        (w_ic_idx)
  );

  lfq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_match_dc (
    .i_addr       (bus.dc_req_addr),
    .i_valid      (r_valid),
    .i_entry_addr (r_addr),
    .i_exclude    (w_excl),
    .o_hit        (w_dc_hit),
    .o_idx        (w_dc_idx)
  );

  always_comb begin
    w_valid_d = r_valid;
    w_addr_d  = r_addr;
    w_mask_d  = r_mask;
    w_head_d  = r_head;
    w_tail_d  = r_tail;
    w_dc_slot = r_tail;
    w_allocs  = '0;
    w_merges  = '0;
    if (w_pop) begin
      w_valid_d[r_head] = 1'b0;
      w_mask_d[r_head]  = '0;
      w_head_d          = ptr_inc(r_head);
    end
    if (w_dc_acc) begin
      if (w_dc_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_dc_idx[i]) w_mask_d[i][SRC_DC] = 1'b1;
        end
        w_merges = w_merges + 2'd1;
      end else begin
        w_valid_d[w_tail_d]        = 1'b1;
        w_addr_d[w_tail_d]         = bus.dc_req_addr;
        w_mask_d[w_tail_d]         = '0;
        w_mask_d[w_tail_d][SRC_DC] = 1'b1;
        w_tail_d                   = ptr_inc(w_tail_d);
        w_allocs                   = w_allocs + 2'd1;
      end
    end
    // IC goes second so a same-cycle DC allocation is visible to it.
    if (w_ic_acc) begin
      if (w_ic_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_ic_idx[i]) w_mask_d[i][SRC_IC] = 1'b1;
        end
        w_merges = w_merges + 2'd1;
      end else if (w_same) begin
        w_mask_d[w_dc_slot][SRC_IC] = 1'b1;
        w_merges                    = w_merges + 2'd1;
      end else begin
        w_valid_d[w_tail_d]        = 1'b1;
        w_addr_d[w_tail_d]         = bus.ic_req_addr;
        w_mask_d[w_tail_d]         = '0;
        w_mask_d[w_tail_d][SRC_IC] = 1'b1;
        w_tail_d                   = ptr_inc(w_tail_d);
        w_allocs                   = w_allocs + 2'd1;
      end
    end
    w_count_d = r_count + NUM_W'(w_allocs) - NUM_W'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_merged <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_mask[i] <= '0;
      end
    end else begin
      r_valid  <= w_valid_d;
      r_addr   <= w_addr_d;
      r_mask   <= w_mask_d;
      r_head   <= w_head_d;
      r_tail   <= w_tail_d;
      r_count  <= w_count_d;
      r_merged <= r_merged + CNT_W'(w_merges);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_issued <= '0;
    end else begin
      unique case (r_state)
        StIdle: if (r_count != '0) r_state <= StReq;
        StReq: begin
          if (bus.mem_req_ready) begin
            r_issued <= r_issued + CNT_W'(1);
            r_state  <= StWait;
          end
        end
        StWait: begin
          if (bus.mem_resp_valid) r_state <= (w_count_d != '0) ? StReq : StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.mem_req_valid = (r_state == StReq);
  assign bus.mem_req_addr  = (r_state == StReq) ? r_addr[r_head] : '0;
  assign bus.ic_fill_done  = w_pop && r_mask[r_head][SRC_IC];
  assign bus.dc_fill_done  = w_pop && r_mask[r_head][SRC_DC];
  assign bus.issued_count  = r_issued;
  assign bus.merged_count  = r_merged;
  assign bus.empty         = (r_count == '0);

endmodule

// File: tb/tb_line_fill_queue.sv
// Directed bench for line_fill_queue: a per-cycle vector table plus short
// hand-written sequences for merge-into-head, re-request on pop and reset.
module tb_line_fill_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  line_fill_queue_if #(.ADDR_W(26), .CNT_W(32)) bus ();

  line_fill_queue #(.DEPTH(4), .ADDR_W(26), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        icv;
    logic [25:0] ica;
    logic        dcv;
    logic [25:0] dca;
    logic        mrdy;
    logic        resp;
    logic        rdy;
    logic        mv;
    logic [25:0] ma;
    logic        icd;
    logic        dcd;
    logic        emp;
    int          iss;
    int          mrg;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, return at the falling edge.
  task automatic cyc(input logic icv, input logic [25:0] ica, input logic dcv,
                     input logic [25:0] dca, input logic mrdy, input logic resp,
                     input logic r);
    @(posedge clk);
    #1;
    rst                = r;
    bus.ic_req_valid   = icv;
    bus.ic_req_addr    = ica;
    bus.dc_req_valid   = dcv;
    bus.dc_req_addr    = dca;
    bus.mem_req_ready  = mrdy;
    bus.mem_resp_valid = resp;
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b0, r);
  endtask

  initial begin
    bus.ic_req_valid   = 1'b0;
    bus.ic_req_addr    = '0;
    bus.dc_req_valid   = 1'b0;
    bus.dc_req_addr    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;

    //            icv  ica            dcv  dca           rdy  rsp  | rdy  mv   ma           icd  dcd  emp iss mrg
    tbl[0]  = '{1'b1, 26'h0000ABC, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 0, 0};
    tbl[1]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b1, 1'b0, 1'b1, 1'b1, 26'h0000ABC, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b0, 1, 0};
    tbl[4]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b0, 1, 0};
    tbl[5]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b1, 1'b1, 1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 1, 0};
    tbl[6]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1, 0};
    tbl[7]  = '{1'b1, 26'h1234567, 1'b1, 26'h1234567, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1, 0};
    tbl[8]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b0, 1, 1};
    tbl[9]  = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b1, 1'b0, 1'b1, 1'b1, 26'h1234567, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[10] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b0, 2, 1};
    tbl[11] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b1, 1'b1, 1'b0, 26'h0,       1'b1, 1'b1, 1'b0, 2, 1};
    tbl[12] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 2, 1};
    tbl[13] = '{1'b1, 26'h0000100, 1'b1, 26'h0000200, 1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 2, 1};
    tbl[14] = '{1'b1, 26'h0000300, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b0, 2, 1};
    tbl[15] = '{1'b0, 26'h0,       1'b1, 26'h0000400, 1'b0, 1'b0, 1'b0, 1'b1, 26'h0000200, 1'b0, 1'b0, 1'b0, 2, 1};
    tbl[16] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 1'b1, 26'h0000200, 1'b0, 1'b0, 1'b0, 2, 1};
    tbl[17] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b1, 1'b0, 1'b0, 26'h0,       1'b0, 1'b1, 1'b0, 3, 1};
    tbl[18] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b1, 1'b0, 1'b1, 1'b1, 26'h0000100, 1'b0, 1'b0, 1'b0, 3, 1};
    tbl[19] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b1, 1'b1, 1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 4, 1};
    tbl[20] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b1, 1'b0, 1'b1, 1'b1, 26'h0000300, 1'b0, 1'b0, 1'b0, 4, 1};
    tbl[21] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b1, 1'b1, 1'b0, 26'h0,       1'b1, 1'b0, 1'b0, 5, 1};
    tbl[22] = '{1'b0, 26'h0,       1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 1'b0, 26'h0,       1'b0, 1'b0, 1'b1, 5, 1};

    // Reset state, sampled while reset is still held.
    idle(1'b1);
    idle(1'b1);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst mem_req_addr", 32'(bus.mem_req_addr), 32'd0);
    chk("rst ic_fill_done", 32'(bus.ic_fill_done), 32'd0);
    chk("rst dc_fill_done", 32'(bus.dc_fill_done), 32'd0);
    chk("rst empty", 32'(bus.empty), 32'd1);
    chk("rst issued", bus.issued_count, 32'd0);
    chk("rst merged", bus.merged_count, 32'd0);

    // Single request, same-cycle pair, back-pressure with dropped 4th request.
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].icv, tbl[i].ica, tbl[i].dcv, tbl[i].dca, tbl[i].mrdy, tbl[i].resp, 1'b0);
      chk($sformatf("row%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d mem_req_valid", i), 32'(bus.mem_req_valid), 32'(tbl[i].mv));
      if (tbl[i].mv) chk($sformatf("row%0d mem_req_addr", i), 32'(bus.mem_req_addr), 32'(tbl[i].ma));
      chk($sformatf("row%0d ic_fill_done", i), 32'(bus.ic_fill_done), 32'(tbl[i].icd));
      chk($sformatf("row%0d dc_fill_done", i), 32'(bus.dc_fill_done), 32'(tbl[i].dcd));
      chk($sformatf("row%0d empty", i), 32'(bus.empty), 32'(tbl[i].emp));
      chk($sformatf("row%0d issued", i), bus.issued_count, 32'(tbl[i].iss));
      chk($sformatf("row%0d merged", i), bus.merged_count, 32'(tbl[i].mrg));
    end

    // Merge an IC request into a DC head that is already waiting.
    idle(1'b1);
    cyc(1'b0, 26'h0, 1'b1, 26'h10, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b1, 1'b0, 1'b0);
    chk("mh mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("mh mem_req_addr", 32'(bus.mem_req_addr), 32'h10);
    cyc(1'b1, 26'h10, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("mh issued", bus.issued_count, 32'd1);
    idle(1'b0);
    chk("mh merged", bus.merged_count, 32'd1);
    chk("mh wait valid", 32'(bus.mem_req_valid), 32'd0);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b1, 1'b0);
    chk("mh ic_fill_done", 32'(bus.ic_fill_done), 32'd1);
    chk("mh dc_fill_done", 32'(bus.dc_fill_done), 32'd1);
    idle(1'b0);
    chk("mh empty", 32'(bus.empty), 32'd1);
    idle(1'b0);
    chk("mh no reissue", 32'(bus.mem_req_valid), 32'd0);
    chk("mh issued end", bus.issued_count, 32'd1);

    // Re-request of the head line in the cycle its response arrives.
    idle(1'b1);
    cyc(1'b1, 26'h55, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b1, 26'h55, 1'b0, 26'h0, 1'b0, 1'b1, 1'b0);
    chk("rr ic_fill_done", 32'(bus.ic_fill_done), 32'd1);
    chk("rr dc_fill_done", 32'(bus.dc_fill_done), 32'd0);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b1, 1'b0, 1'b0);
    chk("rr second valid", 32'(bus.mem_req_valid), 32'd1);
    chk("rr second addr", 32'(bus.mem_req_addr), 32'h55);
    chk("rr merged", bus.merged_count, 32'd0);
    chk("rr empty", 32'(bus.empty), 32'd0);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b1, 1'b0);
    chk("rr issued", bus.issued_count, 32'd2);
    chk("rr second fill", 32'(bus.ic_fill_done), 32'd1);
    idle(1'b0);
    chk("rr empty end", 32'(bus.empty), 32'd1);

    // Reset while waiting with two entries, then a stale response.
    idle(1'b1);
    cyc(1'b1, 26'h20, 1'b1, 26'h30, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b1, 1'b0, 1'b0);
    chk("rw first addr", 32'(bus.mem_req_addr), 32'h30);
    idle(1'b1);
    chk("rw pre issued", bus.issued_count, 32'd1);
    chk("rw pre empty", 32'(bus.empty), 32'd0);
    cyc(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 1'b1, 1'b0);
    chk("rw empty", 32'(bus.empty), 32'd1);
    chk("rw ic_fill_done", 32'(bus.ic_fill_done), 32'd0);
    chk("rw dc_fill_done", 32'(bus.dc_fill_done), 32'd0);
    chk("rw issued", bus.issued_count, 32'd0);
    chk("rw merged", bus.merged_count, 32'd0);
    chk("rw req_ready", 32'(bus.req_ready), 32'd1);
    idle(1'b0);
    chk("rw idle valid", 32'(bus.mem_req_valid), 32'd0);
    cyc(1'b1, 26'h40, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0);
    chk("rw idle valid2", 32'(bus.mem_req_valid), 32'd0);
    idle(1'b0);
    idle(1'b0);
    chk("rw new valid", 32'(bus.mem_req_valid), 32'd1);
    chk("rw new addr", 32'(bus.mem_req_addr), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
